// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for a shared tristate bus: one owner at a time, one dead cycle between owners.
// Optional feature macro ARB_TIMEOUT_EN bounds each ownership to MAX_HOLD cycles.

module tristate_buffer_bus #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output tri   [WIDTH-1:0] data_out
);

  assign data_out = en ? data_in : {WIDTH{1'bz}};

endmodule

module bus_arbiter_rr #(
  parameter  int NUM_REQ  = 4,
  parameter  int WIDTH    = 8,
  parameter  int MAX_HOLD = 16,
  localparam int OW       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       done,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output tri   [WIDTH-1:0]         bus,
  output logic [NUM_REQ-1:0]       grant,
  output logic [OW-1:0]            owner,
  output logic                     bus_busy,
  output logic                     timeout
);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } state_e;

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("bus_arbiter_rr: NUM_REQ must be at least 2");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("bus_arbiter_rr: MAX_HOLD must be at least 1");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      last_q,  last_d;
  logic [OW-1:0]      pick_idx;
  logic               pick_valid;
  logic               owner_release;

  // Nearest set bit after 'last' wins; 'last' itself is tried only after all others.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [OW-1:0]      last);
    logic [OW-1:0] pick;
    logic [OW-1:0] cand;
    int            idx;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = OW'(idx);
      if (r[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign pick_valid    = |req;
  assign pick_idx      = rr_pick(req, last_q);
  assign owner_release = done[owner_q] | ~req[owner_q];

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;
  logic          hold_expired;
  logic          force_release;

  // hold_q counts completed OWN cycles minus one, so expiry lands on the MAX_HOLD-th OWN edge.
  assign hold_expired = (hold_q == HW'(MAX_HOLD - 1));
`endif

  // NOTE: every variable written here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    force_release = 1'b0;
`endif
    unique case (state_q)
      IDLE, TURN: begin
        grant_d = '0;
        if (pick_valid) begin
          state_d           = OWN;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          last_d            = pick_idx;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (owner_release) begin
          state_d = TURN;
          grant_d = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_expired) begin
          state_d       = TURN;
          grant_d       = '0;
          force_release = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    hold_d    = (state_q == OWN) ? hold_q + HW'(1) : '0;
    timeout_d = force_release;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_drv
    tristate_buffer_bus #(
      .WIDTH(WIDTH)
    ) u_drv (
      .en      (grant_q[i]),
      .data_in (req_data[i*WIDTH +: WIDTH]),
      .data_out(bus)
    );
  end

  assign grant    = grant_q;
  assign owner    = owner_q;
  assign bus_busy = |grant_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: vector table, hand sequences, then random traffic vs a model.
// Build with ARB_TIMEOUT_EN defined to exercise the forced-release path.

module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N*W-1:0] req_data;
  tri   [W-1:0]   bus;
  logic [N-1:0]   grant;
  logic [1:0]     owner;
  logic           bus_busy;
  logic           timeout;

  int checks = 0;
  int errors = 0;

  bus_arbiter_rr #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .MAX_HOLD(MH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .req_data(req_data),
    .bus     (bus),
    .grant   (grant),
    .owner   (owner),
    .bus_busy(bus_busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks who owns the bus from the arbitration rules directly.
  typedef enum int { M_IDLE, M_OWN, M_TURN } mstate_e;
  mstate_e m_state   = M_IDLE;
  int      m_owner   = 0;
  int      m_last    = N - 1;
  bit      m_timeout = 1'b0;
`ifdef ARB_TIMEOUT_EN
  int      m_hold    = 0;
`endif

  function automatic int rr_choose(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_edge(input logic r_rst, input logic [N-1:0] r,
                                     input logic [N-1:0] d);
    int p;
    if (r_rst) begin
      m_state   = M_IDLE;
      m_owner   = 0;
      m_last    = N - 1;
      m_timeout = 1'b0;
`ifdef ARB_TIMEOUT_EN
      m_hold    = 0;
`endif
      return;
    end
    m_timeout = 1'b0;
    if (m_state == M_OWN) begin
      if (d[m_owner] || !r[m_owner]) begin
        m_state = M_TURN;
      end else begin
`ifdef ARB_TIMEOUT_EN
        m_hold++;
        if (m_hold == MH) begin
          m_state   = M_TURN;
          m_timeout = 1'b1;
        end
`endif
      end
    end else begin
      p = rr_choose(r, m_last);
      if (p >= 0) begin
        m_state = M_OWN;
        m_owner = p;
        m_last  = p;
`ifdef ARB_TIMEOUT_EN
        m_hold  = 0;
`endif
      end else begin
        m_state = M_IDLE;
      end
    end
  endfunction

  task automatic tick();
    model_edge(rst, req, done);
    @(posedge clk);
    #1;
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic check_bus(input string name, input int idx);
    logic [W-1:0] exp_data;
    exp_data = req_data[idx*W +: W];
    check(name, 32'(bus), 32'(exp_data));
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] exp_grant;
    int           exp_owner;
  } vec_t;

  vec_t vecs[21];

  initial begin
    logic [N-1:0] exp_g;

    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[6]  = '{1'b0, 4'b0101, 4'b0000, 4'b0001, 0};
    vecs[7]  = '{1'b0, 4'b0101, 4'b0001, 4'b0000, 0};
    vecs[8]  = '{1'b0, 4'b0101, 4'b0000, 4'b0100, 2};
    vecs[9]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 0};
    vecs[10] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 1};
    vecs[11] = '{1'b0, 4'b0010, 4'b1000, 4'b0010, 1};
    vecs[12] = '{1'b0, 4'b1100, 4'b0000, 4'b0000, 0};
    vecs[13] = '{1'b0, 4'b1100, 4'b0000, 4'b0100, 2};
    vecs[14] = '{1'b0, 4'b1100, 4'b0000, 4'b0100, 2};
    vecs[15] = '{1'b1, 4'b1100, 4'b0000, 4'b0000, 0};
    vecs[16] = '{1'b0, 4'b1100, 4'b0000, 4'b0100, 2};
    vecs[17] = '{1'b0, 4'b1100, 4'b0100, 4'b0000, 0};
    vecs[18] = '{1'b0, 4'b1100, 4'b0000, 4'b1000, 3};
    vecs[19] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[20] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0};

    rst      = 1'b1;
    req      = '0;
    done     = '0;
    req_data = '0;

    // Directed vectors: reset, basic grant/handover, non-owner done, req drop, mid-ownership reset.
    for (int i = 0; i < 21; i++) begin
      rst      = vecs[i].rst;
      req      = vecs[i].req;
      done     = vecs[i].done;
      req_data = {$urandom, $urandom};
      tick();
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d_busy", i), 32'(bus_busy), 32'(|vecs[i].exp_grant));
      check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'd0);
      if (vecs[i].exp_grant != '0) begin
        check($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].exp_owner));
        check_bus($sformatf("vec%0d_bus", i), vecs[i].exp_owner);
      end
    end

    // All four requesting, each owner holds two cycles: strict rotation with one dead cycle.
    rst  = 1'b0;
    req  = '1;
    done = '0;
    for (int r = 0; r < 5; r++) begin
      exp_g = N'(1) << (r % N);
      req_data = {$urandom, $urandom};
      tick();
      check($sformatf("rot%0d_grant", r), 32'(grant), 32'(exp_g));
      check($sformatf("rot%0d_owner", r), 32'(owner), 32'(r % N));
      check_bus($sformatf("rot%0d_bus", r), r % N);
      tick();
      check($sformatf("rot%0d_hold", r), 32'(grant), 32'(exp_g));
      done = exp_g;
      tick();
      check($sformatf("rot%0d_turn", r), 32'(grant), 32'd0);
      check($sformatf("rot%0d_turn_busy", r), 32'(bus_busy), 32'd0);
      done = '0;
    end

    // Owner 0 never releases while requester 1 waits.
    rst = 1'b1;
    req = 4'b0011;
    tick();
    check("hold_reset_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    tick();
    check("hold_first_grant", 32'(grant), 32'b0001);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c < MH; c++) begin
      tick();
      check($sformatf("hold%0d_grant", c), 32'(grant), 32'b0001);
      check($sformatf("hold%0d_timeout", c), 32'(timeout), 32'd0);
    end
    tick();
    check("forced_release_grant", 32'(grant), 32'd0);
    check("forced_release_timeout", 32'(timeout), 32'd1);
    tick();
    check("after_timeout_grant", 32'(grant), 32'b0010);
    check("after_timeout_pulse", 32'(timeout), 32'd0);
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      check($sformatf("hold%0d_grant", c), 32'(grant), 32'b0001);
      check($sformatf("hold%0d_timeout", c), 32'(timeout), 32'd0);
    end
`endif

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] exp_rg;
      rst = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
        done[b] = ($urandom_range(0, 5) == 0);
      end
      req_data = {$urandom, $urandom};
      tick();
      exp_rg = (m_state == M_OWN) ? (N'(1) << m_owner) : '0;
      check("rnd_grant", 32'(grant), 32'(exp_rg));
      check("rnd_busy", 32'(bus_busy), 32'(m_state == M_OWN));
      check("rnd_timeout", 32'(timeout), 32'(m_timeout));
      if (m_state == M_OWN) begin
        check("rnd_owner", 32'(owner), 32'(m_owner));
        check_bus("rnd_bus", m_owner);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
